rr_pipe_shifter: RTL and testbench

RR_PIPE_SHIFTER -- requirements
Module: rr_pipe_shifter

---
 rtl/shifter_pkg.sv | 36 +++
 rtl/stage_rr.sv | 50 +++++
 rtl/rr_pipe_shifter.sv | 79 +++++++
 tb/tb_rr_pipe_shifter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// ============================================================================
// Module      : shifter_pkg
// Description : Shared widths, op encoding and stage payload for rr_pipe_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

  localparam int WIDTH = 64;
  localparam int SHW   = 6;
  localparam int TAGW  = 4;

  typedef enum logic [1:0] {
    OP_ROR = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } shift_op_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amount;
    shift_op_e        op;
    logic             fill;
    logic [TAGW-1:0]  tag;
  } stage_t;

  // Encoding 3 is reserved and behaves as a rotate.
  function automatic shift_op_e decode_op(input logic [1:0] raw);
    return (raw == 2'd3) ? OP_ROR : shift_op_e'(raw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_rr.sv
// ============================================================================
// Module      : stage_rr
// Description : One registered right shift/rotate stage by a fixed SHAMT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_rr
  import shifter_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_advance,
  input  stage_t i_stage,
  output stage_t o_stage
);

  localparam int c_amt_bit = $clog2(SHAMT);

  logic [WIDTH-1:0] w_shifted;
  stage_t           w_next;
  stage_t           r_stage;

  always_comb begin
    case (i_stage.op)
      OP_SRL:  w_shifted = {{SHAMT{1'b0}}, i_stage.data[WIDTH-1:SHAMT]};
      OP_SRA:  w_shifted = {{SHAMT{i_stage.fill}}, i_stage.data[WIDTH-1:SHAMT]};
      default: w_shifted = {i_stage.data[SHAMT-1:0], i_stage.data[WIDTH-1:SHAMT]};
    endcase
    w_next = i_stage;
    if (i_stage.amount[c_amt_bit]) begin
      w_next.data = w_shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else if (i_advance) begin
      r_stage <= w_next;
    end
  end

  assign o_stage = r_stage;

endmodule

`default_nettype wire

// File: rtl/rr_pipe_shifter.sv
// ============================================================================
// Module      : rr_pipe_shifter
// Description : Six-stage pipelined 64-bit right rotate / logical / arithmetic
//               shifter with valid/ready handshake and a sideband tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pipe_shifter #(
  parameter int WIDTH = shifter_pkg::WIDTH,
  parameter int SHW   = shifter_pkg::SHW,
  parameter int TAGW  = shifter_pkg::TAGW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shift_amount,
  input  logic [1:0]       op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);

  import shifter_pkg::*;

  stage_t w_head;
  stage_t w_link [0:6];
  logic   w_advance;

  // Whole pipe moves in lockstep; bubbles are kept so ordering and timing hold.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  always_comb begin
    w_head        = '0;
    w_head.valid  = in_valid;
    w_head.data   = in_data;
    w_head.amount = shift_amount;
    w_head.op     = decode_op(op);
    w_head.fill   = in_data[WIDTH-1];
    w_head.tag    = in_tag;
  end

  assign w_link[0] = w_head;

  for (genvar k = 0; k < 6; k++) begin : g_stage
    stage_rr #(
      .SHAMT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_advance),
      .i_stage   (w_link[k]),
      .o_stage   (w_link[k+1])
    );
  end

  assign out_valid = w_link[6].valid;
  assign result    = w_link[6].data;
  assign out_tag   = w_link[6].tag;

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      busy = busy | w_link[k].valid;
    end
  end

  logic w_unused_tail;
  assign w_unused_tail = ^{w_link[6].amount, w_link[6].op, w_link[6].fill};

endmodule

`default_nettype wire

// File: tb/tb_rr_pipe_shifter.sv
// ============================================================================
// Module      : tb_rr_pipe_shifter
// Description : Self-checking bench for rr_pipe_shifter with a scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_pipe_shifter;

  localparam int WIDTH = 64;
  localparam int SHW   = 6;
  localparam int TAGW  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   shift_amount = '0;
  logic [1:0]       op = '0;
  logic [TAGW-1:0]  in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic [TAGW-1:0]  out_tag;
  logic             busy;

  always #5 clk = ~clk;

  rr_pipe_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW),
    .TAGW  (TAGW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shift_amount (shift_amount),
    .op           (op),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAGW-1:0]  tag;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cycle    = 0;
  logic             check_lat  = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_res   = '0;
  logic [TAGW-1:0]  prev_tag   = '0;

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int s,
                                                 input logic [1:0] o);
    case (o)
      2'd1:    return d >> s;
      2'd2:    return WIDTH'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d >> s) | (d << (WIDTH - s)));
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
  endtask

  // One clock cycle: drive at negedge, observe just after, update scoreboard.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                      input logic [1:0] o, input logic [TAGW-1:0] t,
                      input logic [WIDTH-1:0] e, input logic ordy, output logic acc);
    exp_t x;
    @(negedge clk);
    in_valid = v; in_data = d; shift_amount = a; op = o; in_tag = t; out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("hold_result", result, prev_res);
      check("hold_tag", 64'(out_tag), 64'(prev_tag));
    end
    if (!rst) begin
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    end
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        x = exp_q.pop_front();
        check("result", result, x.res);
        check("tag", 64'(out_tag), 64'(x.tag));
        if (check_lat) check("latency", 64'(cycle - x.cyc), 64'd6);
      end
    end
    acc = v && in_ready && !rst;
    if (acc) exp_q.push_back('{e, t, cycle});
    prev_stall = out_valid && !out_ready && !rst;
    prev_res   = result;
    prev_tag   = out_tag;
    cycle++;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a, input logic [1:0] o,
                      input logic [TAGW-1:0] t, input logic [WIDTH-1:0] e, input logic rand_ready);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      step(1'b1, d, a, o, t, e, rand_ready ? 1'($urandom % 2) : 1'b1, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, '0, '0, '0, '0, ordy, acc);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      idle(1'b1);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_after_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic             acc;
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   a;
    logic [1:0]       o;

    // Reset with an input presented: it must not be accepted.
    rst = 1'b1;
    repeat (2) step(1'b1, 64'h1234, 6'd3, 2'd0, 4'd7, 64'h0, 1'b0, acc);
    check_after_reset();
    repeat (8) idle(1'b1);

    // Directed vectors with exact latency.
    check_lat = 1'b1;
    send(64'h0000_0000_0000_0001, 6'd1, 2'd0, 4'd1, 64'h8000_0000_0000_0000, 1'b0);
    drain();
    send(64'h8000_0000_0000_00F0, 6'd4, 2'd2, 4'd2, 64'hF800_0000_0000_000F, 1'b0);
    send(64'h8000_0000_0000_00F0, 6'd4, 2'd1, 4'd3, 64'h0800_0000_0000_000F, 1'b0);
    send(64'h0000_0000_0000_0001, 6'd63, 2'd0, 4'd4, 64'h0000_0000_0000_0002, 1'b0);
    send(64'h8000_0000_0000_0001, 6'd63, 2'd2, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h8000_0000_0000_0001, 6'd63, 2'd1, 4'd6, 64'h0000_0000_0000_0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(64'hDEAD_BEEF_8765_4321, 6'd0, 2'(i), 4'(8 + i), 64'hDEAD_BEEF_8765_4321, 1'b0);
    end
    send(64'h0000_0000_0000_0001, 6'd1, 2'd3, 4'd12, 64'h8000_0000_0000_0000, 1'b0);
    drain();

    // Ten back-to-back operations, tags 0..9, under random backpressure.
    check_lat = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom};
      a = 6'($urandom);
      o = 2'($urandom);
      send(d, a, o, 4'(i), ref_shift(d, int'(a), o), 1'b1);
    end
    drain();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      send(d, 6'(i + 1), 2'd0, 4'(i), ref_shift(d, i + 1, 2'd0), 1'b0);
    end
    rst = 1'b1;
    step(1'b1, 64'hFFFF, 6'd5, 2'd1, 4'd15, 64'h0, 1'b1, acc);
    check_after_reset();
    repeat (12) idle(1'b1);

    // Random traffic with random valid and ready.
    for (int i = 0; i < 300; i++) begin
      d = {$urandom, $urandom};
      a = 6'($urandom);
      o = 2'($urandom);
      step(($urandom % 4) != 0, d, a, o, 4'(i), ref_shift(d, int'(a), o),
           ($urandom % 3) != 0, acc);
    end
    drain();
    repeat (4) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
